// File: rtl/regfile_sb.sv
// Parametrised register file with two combinational read ports, optional write-to-read bypass,
// optional hard-wired zero register and per-register busy scoreboard; no backpressure, halt freezes all state.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable_halt,
    input  logic [AW-1:0]   rg_rd_addr1,
    input  logic [AW-1:0]   rg_rd_addr2,
    output logic [XLEN-1:0] rg_rd_data1,
    output logic [XLEN-1:0] rg_rd_data2,
    output logic            rg_rd_busy1,
    output logic            rg_rd_busy2,
    input  logic            rg_wrt_en,
    input  logic [AW-1:0]   rg_wrt_dest,
    input  logic [XLEN-1:0] rg_wrt_data,
    input  logic            rsv_en,
    input  logic [AW-1:0]   rsv_dest
);

    logic [XLEN-1:0]     regs_q [NUM_REGS];
    logic [XLEN-1:0]     regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    logic            wr_ok;
    logic            rsv_ok;
    logic [AW-1:0]   rd_addr [2];
    logic [XLEN-1:0] rd_data [2];
    logic            rd_busy [2];
    logic            bp_hit  [2];

    // Accesses to a hard-wired zero register are dropped; halt blocks both writes and the bypass.
    assign wr_ok  = rg_wrt_en && !enable_halt && !((ZERO_REG != 0) && (rg_wrt_dest == '0));
    assign rsv_ok = rsv_en    && !enable_halt && !((ZERO_REG != 0) && (rsv_dest == '0));

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_ok) begin
            regs_d[rg_wrt_dest] = rg_wrt_data;
            busy_d[rg_wrt_dest] = 1'b0;
        end
        // A reservation issued alongside a write to the same register is the newer one.
        if (rsv_ok) begin
            busy_d[rsv_dest] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!enable_halt) begin
            if (rst) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    regs_q[i] <= '0;
                end
                busy_q <= '0;
            end else begin
                regs_q <= regs_d;
                busy_q <= busy_d;
            end
        end
    end

    assign rd_addr[0] = rg_rd_addr1;
    assign rd_addr[1] = rg_rd_addr2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            bp_hit[p]  = (BYPASS != 0) && wr_ok && (rg_wrt_dest == rd_addr[p]);
            rd_data[p] = bp_hit[p] ? rg_wrt_data : regs_q[rd_addr[p]];
            rd_busy[p] = busy_q[rd_addr[p]];
            // Forwarded data is ready unless the same register is re-reserved this cycle.
            if (bp_hit[p] && !(rsv_ok && (rsv_dest == rd_addr[p]))) begin
                rd_busy[p] = 1'b0;
            end
            if ((ZERO_REG != 0) && (rd_addr[p] == '0)) begin
                rd_data[p] = '0;
                rd_busy[p] = 1'b0;
            end
        end
    end

    assign rg_rd_data1 = rd_data[0];
    assign rg_rd_data2 = rd_data[1];
    assign rg_rd_busy1 = rd_busy[0];
    assign rg_rd_busy2 = rd_busy[1];

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: default instance plus a 16x64, no-zero-register, no-bypass instance on shared stimulus.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable_halt = 1'b0;
    logic [4:0]  rd_addr1 = '0;
    logic [4:0]  rd_addr2 = '0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_dest = '0;
    logic [31:0] wr_data = '0;
    logic        rsv_en = 1'b0;
    logic [4:0]  rsv_dest = '0;

    logic [31:0] a_data1, a_data2;
    logic        a_busy1, a_busy2;
    logic [63:0] b_data1, b_data2;
    logic        b_busy1, b_busy2;
    logic [63:0] wr_data64;

    int total = 0;
    int bad   = 0;

    assign wr_data64 = {~wr_data, wr_data};

    always #5 clk = ~clk;

    regfile_sb dut_a (
        .clk(clk), .rst(rst), .enable_halt(enable_halt),
        .rg_rd_addr1(rd_addr1), .rg_rd_addr2(rd_addr2),
        .rg_rd_data1(a_data1), .rg_rd_data2(a_data2),
        .rg_rd_busy1(a_busy1), .rg_rd_busy2(a_busy2),
        .rg_wrt_en(wr_en), .rg_wrt_dest(wr_dest), .rg_wrt_data(wr_data),
        .rsv_en(rsv_en), .rsv_dest(rsv_dest)
    );

    regfile_sb #(.XLEN(64), .NUM_REGS(16), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .enable_halt(enable_halt),
        .rg_rd_addr1(rd_addr1[3:0]), .rg_rd_addr2(rd_addr2[3:0]),
        .rg_rd_data1(b_data1), .rg_rd_data2(b_data2),
        .rg_rd_busy1(b_busy1), .rg_rd_busy2(b_busy2),
        .rg_wrt_en(wr_en), .rg_wrt_dest(wr_dest[3:0]), .rg_wrt_data(wr_data64),
        .rsv_en(rsv_en), .rsv_dest(rsv_dest[3:0])
    );

    // Inputs change #1 after the posedge; combinational checks are made #2 after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; enable_halt = 1'b0; wr_en = 1'b0; rsv_en = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rd_addr1 = 5'(i);
            rd_addr2 = 5'(31 - i);
            #1;
            total++;
            if (a_data1 !== 32'h0 || a_busy1 !== 1'b0 || a_data2 !== 32'h0 || a_busy2 !== 1'b0) begin
                bad++;
                $display("FAIL reset_a addr=%0d got d1=%h b1=%b d2=%h b2=%b want 0", i, a_data1, a_busy1, a_data2, a_busy2);
            end
            if (i < 16) begin
                total++;
                if (b_data1 !== 64'h0 || b_busy1 !== 1'b0) begin
                    bad++;
                    $display("FAIL reset_b addr=%0d got d1=%h b1=%b want 0", i, b_data1, b_busy1);
                end
            end
        end
        wr_en = 1'b1; wr_dest = 5'd5; wr_data = 32'hDEADBEEF;
        tick();
        wr_en = 1'b0; rd_addr1 = 5'd5; rd_addr2 = 5'd5;
        #1;
        total++;
        if (a_data1 !== 32'hDEADBEEF || a_data2 !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL write_r5_a got %h/%h want deadbeef", a_data1, a_data2);
        end
        total++;
        if (b_data2 !== 64'h21524110DEADBEEF) begin
            bad++;
            $display("FAIL write_r5_b got %h want 21524110deadbeef", b_data2);
        end
    endtask

    task automatic test_bypass();
        idle();
        rsv_en = 1'b1; rsv_dest = 5'd7;
        tick();
        rsv_en = 1'b0;
        wr_en = 1'b1; wr_dest = 5'd7; wr_data = 32'h1234; rd_addr1 = 5'd7;
        #1;
        total++;
        if (a_data1 !== 32'h1234 || a_busy1 !== 1'b0) begin
            bad++;
            $display("FAIL bypass_a got d=%h b=%b want 1234/0", a_data1, a_busy1);
        end
        total++;
        if (b_data1 !== 64'h0 || b_busy1 !== 1'b1) begin
            bad++;
            $display("FAIL nobypass_b got d=%h b=%b want 0/1", b_data1, b_busy1);
        end
        tick();
        wr_en = 1'b0;
        #1;
        total++;
        if (b_data1 !== 64'hFFFFEDCB00001234 || b_busy1 !== 1'b0 || a_data1 !== 32'h1234 || a_busy1 !== 1'b0) begin
            bad++;
            $display("FAIL after_bypass got a=%h/%b b=%h/%b want 1234/0 ffffedcb00001234/0", a_data1, a_busy1, b_data1, b_busy1);
        end
    endtask

    task automatic test_zero_reg();
        idle();
        wr_en = 1'b1; wr_dest = 5'd0; wr_data = 32'hFFFFFFFF;
        rsv_en = 1'b1; rsv_dest = 5'd0; rd_addr1 = 5'd0; rd_addr2 = 5'd0;
        #1;
        total++;
        if (a_data1 !== 32'h0 || a_busy1 !== 1'b0) begin
            bad++;
            $display("FAIL zero_bypass_a got d=%h b=%b want 0/0", a_data1, a_busy1);
        end
        tick();
        idle();
        #1;
        total++;
        if (a_data2 !== 32'h0 || a_busy2 !== 1'b0) begin
            bad++;
            $display("FAIL zero_reg_a got d=%h b=%b want 0/0", a_data2, a_busy2);
        end
        total++;
        if (b_data2 !== 64'h00000000FFFFFFFF || b_busy2 !== 1'b1) begin
            bad++;
            $display("FAIL r0_ordinary_b got d=%h b=%b want 00000000ffffffff/1", b_data2, b_busy2);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        rsv_en = 1'b1; rsv_dest = 5'd3; rd_addr1 = 5'd3; rd_addr2 = 5'd8;
        tick();
        rsv_en = 1'b0;
        #1;
        total++;
        if (a_busy1 !== 1'b1 || b_busy1 !== 1'b1) begin
            bad++;
            $display("FAIL rsv_r3 got a=%b b=%b want 1/1", a_busy1, b_busy1);
        end
        wr_en = 1'b1; wr_dest = 5'd3; wr_data = 32'h55; rsv_en = 1'b1; rsv_dest = 5'd3;
        #1;
        total++;
        if (a_data1 !== 32'h55 || a_busy1 !== 1'b1) begin
            bad++;
            $display("FAIL wr_rsv_same_bypass got d=%h b=%b want 55/1", a_data1, a_busy1);
        end
        tick();
        wr_en = 1'b0; rsv_en = 1'b0;
        #1;
        total++;
        if (a_data1 !== 32'h55 || a_busy1 !== 1'b1 || b_data1 !== 64'hFFFFFFAA00000055 || b_busy1 !== 1'b1) begin
            bad++;
            $display("FAIL wr_rsv_same got a=%h/%b b=%h/%b want 55/1 ffffffaa00000055/1", a_data1, a_busy1, b_data1, b_busy1);
        end
        // write r3 while reserving r8: independent effects
        wr_en = 1'b1; wr_data = 32'h66; rsv_en = 1'b1; rsv_dest = 5'd8;
        tick();
        wr_en = 1'b0; rsv_en = 1'b0;
        #1;
        total++;
        if (a_data1 !== 32'h66 || a_busy1 !== 1'b0 || a_busy2 !== 1'b1 || b_busy1 !== 1'b0 || b_busy2 !== 1'b1) begin
            bad++;
            $display("FAIL wr_rsv_diff got a=%h/%b/%b b=%b/%b want 66/0/1 0/1", a_data1, a_busy1, a_busy2, b_busy1, b_busy2);
        end
    endtask

    task automatic test_halt();
        idle();
        wr_en = 1'b1; wr_dest = 5'd9; wr_data = 32'h11;
        tick();
        enable_halt = 1'b1; rst = 1'b1;
        wr_data = 32'hAA; rsv_en = 1'b1; rsv_dest = 5'd10;
        rd_addr1 = 5'd9; rd_addr2 = 5'd10;
        #1;
        total++;
        if (a_data1 !== 32'h11 || a_busy1 !== 1'b0) begin
            bad++;
            $display("FAIL halt_no_bypass got d=%h b=%b want 11/0", a_data1, a_busy1);
        end
        tick();
        tick();
        #1;
        total++;
        if (a_data1 !== 32'h11 || a_busy2 !== 1'b0 || b_data1 !== 64'hFFFFFFEE00000011 || b_busy2 !== 1'b0) begin
            bad++;
            $display("FAIL halt_frozen got a=%h/%b b=%h/%b want 11/0 ffffffee00000011/0", a_data1, a_busy2, b_data1, b_busy2);
        end
        rd_addr2 = 5'd5;
        #1;
        total++;
        if (a_data2 !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL halt_blocks_rst got %h want deadbeef", a_data2);
        end
        enable_halt = 1'b0; rst = 1'b0; rsv_en = 1'b0;
        rd_addr2 = 5'd10;
        tick();
        wr_en = 1'b0; rsv_en = 1'b1; rsv_dest = 5'd10;
        tick();
        rsv_en = 1'b0;
        #1;
        total++;
        if (a_data1 !== 32'hAA || a_busy2 !== 1'b1 || b_data1 !== 64'hFFFFFF55000000AA) begin
            bad++;
            $display("FAIL halt_resume got a=%h/%b b=%h want aa/1 ffffff55000000aa", a_data1, a_busy2, b_data1);
        end
    endtask

    task automatic test_mid_reset();
        idle();
        wr_en = 1'b1; wr_dest = 5'd4; wr_data = 32'h77; rsv_en = 1'b1; rsv_dest = 5'd6;
        rst = 1'b1;
        tick();
        idle();
        rd_addr1 = 5'd4; rd_addr2 = 5'd6;
        #1;
        total++;
        if (a_data1 !== 32'h0 || a_busy2 !== 1'b0 || b_data1 !== 64'h0 || b_busy2 !== 1'b0) begin
            bad++;
            $display("FAIL mid_rst got a=%h/%b b=%h/%b want 0/0 0/0", a_data1, a_busy2, b_data1, b_busy2);
        end
        for (int i = 0; i < 16; i++) begin
            rd_addr1 = 5'(i);
            rd_addr2 = 5'(i + 16);
            #1;
            total++;
            if (a_busy1 !== 1'b0 || a_busy2 !== 1'b0 || b_busy1 !== 1'b0 || a_data1 !== 32'h0 || b_data1 !== 64'h0) begin
                bad++;
                $display("FAIL mid_rst_sweep addr=%0d got a=%h/%b/%b b=%h/%b want zeros", i, a_data1, a_busy1, a_busy2, b_data1, b_busy1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_halt();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
